data_memory_ctrl: RTL and testbench

Parametrised, byte-addressed, little-endian data memory with a request/response handshake, selectable access size (byte/half/word/double), sign- or zero-extended loads, alignment and range fault detection, configurable wait states, and a post-reset memory-clear sweep. It sits behind the processor's memory stage and replaces the fixed 32-bit, combinational-read data memory. The pipeline stalls on `req_ready`/`resp_valid`.

---
 rtl/data_memory_ctrl_pkg.sv | 21 ++
 rtl/data_memory_ctrl_load_align.sv | 34 +++
 rtl/data_memory_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_ctrl_pkg.sv
// Shared definitions for the data memory controller: access-size encodings,
// FSM states and the size-to-byte-count helper.
package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } mem_state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/data_memory_ctrl_load_align.sv
// Load result formatting: picks the low 2^size bytes of a little-endian
// doubleword and sign- or zero-extends them to 64 bits.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [63:0] i_raw,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [63:0] o_data
);

    logic w_sign;

    always_comb begin
        w_sign = 1'b0;
        o_data = i_raw;
        case (i_size)
            SIZE_B: begin
                w_sign = !i_unsigned && i_raw[7];
                o_data = {{56{w_sign}}, i_raw[7:0]};
            end
            SIZE_H: begin
                w_sign = !i_unsigned && i_raw[15];
                o_data = {{48{w_sign}}, i_raw[15:0]};
            end
            SIZE_W: begin
                w_sign = !i_unsigned && i_raw[31];
                o_data = {{32{w_sign}}, i_raw[31:0]};
            end
            default: o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed little-endian data memory with request/response handshake,
// sized loads/stores, fault detection, wait states and a post-reset clear sweep.
module data_memory_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 512,
    parameter int ADDR_WIDTH  = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [63:0]           req_wdata,
    output logic                  resp_valid,
    output logic [63:0]           resp_rdata,
    output logic                  resp_fault,
    output logic                  init_done,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [63:0]           dbg_data
);

    localparam int IDX_W   = $clog2(DEPTH_BYTES);
    localparam int SWEEP_W = (DEPTH_BYTES > 8) ? $clog2(DEPTH_BYTES / 8) : 1;
    localparam logic [SWEEP_W-1:0]  SWEEP_LAST = SWEEP_W'(DEPTH_BYTES / 8 - 1);
    localparam logic [3:0]          WAIT_LOAD  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT  = (ADDR_WIDTH + 1)'(DEPTH_BYTES);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH_BYTES);

    logic [7:0]         r_mem [0:DEPTH_BYTES-1];
    mem_state_t         r_state;
    mem_state_t         w_next_state;
    logic [SWEEP_W-1:0] r_sweep;
    logic [3:0]         r_wait_cnt;

    logic               r_write;
    logic [1:0]         r_size;
    logic               r_unsigned;
    logic               r_fault;
    logic [IDX_W-1:0]   r_idx;
    logic [63:0]        r_wdata;
    logic [63:0]        r_raw;

    logic               r_req_ready;
    logic               r_resp_valid;
    logic [63:0]        r_resp_rdata;
    logic               r_resp_fault;
    logic               r_init_done;

    logic                w_accept;
    logic [3:0]          w_req_nbytes;
    logic [ADDR_WIDTH:0] w_req_end;
    logic                w_misalign;
    logic                w_fault_in;

    logic                w_commit;
    logic                w_c_write;
    logic [1:0]          w_c_size;
    logic                w_c_fault;
    logic [IDX_W-1:0]    w_c_idx;
    logic [63:0]         w_c_wdata;
    logic [3:0]          w_c_nbytes;
    logic [63:0]         w_raw;
    logic [63:0]         w_load_data;
    logic [IDX_W-1:0]    w_sweep_idx;
    logic [IDX_W-1:0]    w_dbg_idx;

    assign w_accept     = (r_state == ST_IDLE) && req_valid;
    assign w_req_nbytes = size_bytes(req_size);
    // One extra bit so addresses near the top of the space cannot wrap past the check.
    assign w_req_end    = {1'b0, req_addr} + (ADDR_WIDTH + 1)'(w_req_nbytes);
    assign w_misalign   = (req_addr[2:0] & (w_req_nbytes[2:0] - 3'd1)) != 3'd0;
    assign w_fault_in   = w_misalign || (w_req_end > DEPTH_EXT);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_INIT: if (r_sweep == SWEEP_LAST) w_next_state = ST_IDLE;
            ST_IDLE: if (req_valid) w_next_state = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (r_wait_cnt == 4'd0) w_next_state = ST_RESP;
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_INIT;
        endcase
    end

    // With no wait states the commit edge is the accept edge, so the request
    // fields come straight from the ports instead of the capture registers.
    assign w_commit   = (w_next_state == ST_RESP) && !reset;
    assign w_c_write  = (r_state == ST_IDLE) ? req_write : r_write;
    assign w_c_size   = (r_state == ST_IDLE) ? req_size : r_size;
    assign w_c_fault  = (r_state == ST_IDLE) ? w_fault_in : r_fault;
    assign w_c_idx    = (r_state == ST_IDLE) ? req_addr[IDX_W-1:0] : r_idx;
    assign w_c_wdata  = (r_state == ST_IDLE) ? req_wdata : r_wdata;
    assign w_c_nbytes = size_bytes(w_c_size);
    assign w_sweep_idx = IDX_W'({r_sweep, 3'b000});

    always_comb begin
        w_raw = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            w_raw[8*k +: 8] = r_mem[w_c_idx + IDX_W'(k)];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == ST_INIT) begin
                for (int unsigned k = 0; k < 8; k++) begin
                    r_mem[w_sweep_idx + IDX_W'(k)] <= '0;
                end
            end else if (w_commit && w_c_write && !w_c_fault) begin
                for (int unsigned k = 0; k < 8; k++) begin
                    if (k < 32'(w_c_nbytes)) begin
                        r_mem[w_c_idx + IDX_W'(k)] <= w_c_wdata[8*k +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_INIT;
            r_sweep      <= '0;
            r_wait_cnt   <= '0;
            r_write      <= 1'b0;
            r_size       <= SIZE_B;
            r_unsigned   <= 1'b0;
            r_fault      <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_raw        <= '0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_fault <= 1'b0;
            r_init_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_INIT && r_sweep != SWEEP_LAST) begin
                r_sweep <= r_sweep + 1'b1;
            end
            if (w_accept) begin
                r_wait_cnt <= WAIT_LOAD;
                r_write    <= req_write;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_fault    <= w_fault_in;
                r_idx      <= req_addr[IDX_W-1:0];
                r_wdata    <= req_wdata;
            end else if (r_state == ST_WAIT && r_wait_cnt != 4'd0) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if (w_commit) begin
                r_raw <= w_raw;
            end
            r_req_ready  <= (w_next_state == ST_IDLE);
            r_init_done  <= r_init_done || (w_next_state == ST_IDLE);
            r_resp_valid <= (r_state == ST_RESP);
            r_resp_fault <= (r_state == ST_RESP) && r_fault;
            r_resp_rdata <= (r_state == ST_RESP && !r_fault && !r_write) ? w_load_data : '0;
        end
    end

    mem_load_align u_load_align (
        .i_raw      (r_raw),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_data)
    );

    assign w_dbg_idx = dbg_addr[IDX_W-1:0] & ~IDX_W'(7);

    always_comb begin
        dbg_data = '0;
        if (dbg_addr < DEPTH_A) begin
            for (int unsigned k = 0; k < 8; k++) begin
                dbg_data[8*k +: 8] = r_mem[w_dbg_idx + IDX_W'(k)];
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_fault = r_resp_fault;
    assign init_done  = r_init_done;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: table-driven loads/stores/faults on a zero-wait instance,
// plus hand sequences for wait-state timing and reset during a transaction.
module tb_data_memory_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_req_valid, a_req_ready, a_req_write, a_req_unsigned;
    logic [1:0]  a_req_size;
    logic [63:0] a_req_addr, a_req_wdata, a_resp_rdata, a_dbg_addr, a_dbg_data;
    logic        a_resp_valid, a_resp_fault, a_init_done;

    logic        b_reset, b_req_valid, b_req_ready, b_req_write, b_req_unsigned;
    logic [1:0]  b_req_size;
    logic [63:0] b_req_addr, b_req_wdata, b_resp_rdata, b_dbg_addr, b_dbg_data;
    logic        b_resp_valid, b_resp_fault, b_init_done;

    data_memory_ctrl #(.DEPTH_BYTES(512), .ADDR_WIDTH(64), .WAIT_STATES(0)) u_dut_a (
        .clk(clk), .reset(a_reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_write(a_req_write), .req_size(a_req_size), .req_unsigned(a_req_unsigned),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .resp_valid(a_resp_valid),
        .resp_rdata(a_resp_rdata), .resp_fault(a_resp_fault), .init_done(a_init_done),
        .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data)
    );

    data_memory_ctrl #(.DEPTH_BYTES(512), .ADDR_WIDTH(64), .WAIT_STATES(3)) u_dut_b (
        .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(b_req_write), .req_size(b_req_size), .req_unsigned(b_req_unsigned),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .resp_valid(b_resp_valid),
        .resp_rdata(b_resp_rdata), .resp_fault(b_resp_fault), .init_done(b_init_done),
        .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int b_pulses = 0;

    always @(negedge clk) if (b_resp_valid) b_pulses++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[17];

    // Issue one request on the zero-wait instance; expects resp_valid on the
    // second sampling point after the accept edge and for one cycle only.
    task automatic a_txn(input vec_t v, input int idx);
        int t;
        t = 0;
        while (!a_req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("v%0d_ready", idx), a_req_ready, 1);
        a_req_valid    = 1'b1;
        a_req_write    = v.wr;
        a_req_size     = v.sz;
        a_req_unsigned = v.uns;
        a_req_addr     = v.addr;
        a_req_wdata    = v.wdata;
        @(negedge clk);
        a_req_valid = 1'b0;
        a_req_wdata = ~v.wdata;
        a_req_addr  = v.addr ^ 64'h8;
        t = 0;
        while (!a_resp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("v%0d_latency", idx), 64'(t), 64'd1);
        check($sformatf("v%0d_valid", idx), a_resp_valid, 1);
        check($sformatf("v%0d_rdata", idx), a_resp_rdata, v.exp_rdata);
        check($sformatf("v%0d_fault", idx), a_resp_fault, v.exp_fault);
        @(negedge clk);
        check($sformatf("v%0d_pulse", idx), a_resp_valid, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses0;

        vecs[0]  = '{1'b1, 2'd3, 1'b0, 64'd256, 64'h8877665544332211, 64'h0, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 64'd263, 64'h0, 64'h0000000000000088, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 64'd263, 64'h0, 64'hFFFFFFFFFFFFFF88, 1'b0};
        vecs[3]  = '{1'b0, 2'd1, 1'b0, 64'd262, 64'h0, 64'hFFFFFFFFFFFF8877, 1'b0};
        vecs[4]  = '{1'b0, 2'd2, 1'b1, 64'd260, 64'h0, 64'h0000000088776655, 1'b0};
        vecs[5]  = '{1'b1, 2'd2, 1'b0, 64'd264, 64'hCAFEF00DDEADBEEF, 64'h0, 1'b0};
        vecs[6]  = '{1'b0, 2'd3, 1'b0, 64'd264, 64'h0, 64'h00000000DEADBEEF, 1'b0};
        vecs[7]  = '{1'b1, 2'd2, 1'b0, 64'd258, 64'hAAAAAAAAAAAAAAAA, 64'h0, 1'b1};
        vecs[8]  = '{1'b0, 2'd3, 1'b0, 64'd256, 64'h0, 64'h8877665544332211, 1'b0};
        vecs[9]  = '{1'b0, 2'd3, 1'b0, 64'd512, 64'h0, 64'h0, 1'b1};
        vecs[10] = '{1'b0, 2'd0, 1'b1, 64'd511, 64'h0, 64'h0, 1'b0};
        vecs[11] = '{1'b0, 2'd1, 1'b0, 64'd260, 64'h0, 64'h0000000000006655, 1'b0};
        vecs[12] = '{1'b0, 2'd2, 1'b0, 64'd260, 64'h0, 64'hFFFFFFFF88776655, 1'b0};
        vecs[13] = '{1'b0, 2'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0, 64'h0, 1'b1};
        vecs[14] = '{1'b1, 2'd1, 1'b0, 64'd510, 64'h00000000000080FF, 64'h0, 1'b0};
        vecs[15] = '{1'b0, 2'd1, 1'b0, 64'd510, 64'h0, 64'hFFFFFFFFFFFF80FF, 1'b0};
        vecs[16] = '{1'b0, 2'd1, 1'b1, 64'd257, 64'h0, 64'h0, 1'b1};

        a_reset = 1'b1; a_req_valid = 1'b0; a_req_write = 1'b0; a_req_size = 2'd0;
        a_req_unsigned = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_dbg_addr = 64'd256;
        b_reset = 1'b1; b_req_valid = 1'b0; b_req_write = 1'b0; b_req_size = 2'd0;
        b_req_unsigned = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_dbg_addr = 64'd296;

        // Reset for two cycles, then count cycles until ready rises.
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", a_req_ready, 0);
        check("rst_resp_valid", a_resp_valid, 0);
        check("rst_rdata", a_resp_rdata, 0);
        check("rst_fault", a_resp_fault, 0);
        check("rst_init_done", a_init_done, 0);
        a_reset = 1'b0;
        b_reset = 1'b0;
        n = 0;
        while (!a_req_ready && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 63) check("init_done_early", a_init_done, 0);
        end
        check("init_cycles", 64'(n), 64'd64);
        check("init_done", a_init_done, 1);
        check("init_dbg_256", a_dbg_data, 0);
        check("b_init_done", b_init_done, 1);

        for (int i = 0; i < 17; i++) begin
            a_txn(vecs[i], i);
        end

        a_dbg_addr = 64'd264;
        #1 check("dbg_264_partial", a_dbg_data, 64'h00000000DEADBEEF);
        a_dbg_addr = 64'd259;
        #1 check("dbg_259_round", a_dbg_data, 64'h8877665544332211);
        a_dbg_addr = 64'd504;
        #1 check("dbg_504_top", a_dbg_data, 64'h80FF000000000000);
        a_dbg_addr = 64'd512;
        #1 check("dbg_512_oor", a_dbg_data, 0);

        // Wait-state timing on the WAIT_STATES=3 instance.
        @(negedge clk);
        check("b_ready_idle", b_req_ready, 1);
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_size = 2'd0;
        b_req_addr = 64'd300; b_req_wdata = 64'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b_req_valid = 1'b0;
            b_req_wdata = 64'hAA;
            check($sformatf("ws_ready_low_%0d", i), b_req_ready, 0);
            check($sformatf("ws_no_resp_%0d", i), b_resp_valid, 0);
        end
        @(negedge clk);
        check("ws_resp_valid", b_resp_valid, 1);
        check("ws_resp_fault", b_resp_fault, 0);
        check("ws_ready_back", b_req_ready, 1);
        check("ws_dbg_store", b_dbg_data, 64'h0000005500000000);
        @(negedge clk);
        check("ws_resp_pulse", b_resp_valid, 0);

        // Reset asserted while the second store sits in WAIT.
        pulses0 = b_pulses;
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_size = 2'd0;
        b_req_addr = 64'd300; b_req_wdata = 64'h66;
        @(negedge clk);
        b_req_valid = 1'b0;
        @(negedge clk);
        b_reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", b_req_ready, 0);
        check("mid_rst_init_done", b_init_done, 0);
        @(negedge clk);
        b_reset = 1'b0;
        n = 0;
        while (!b_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst_reinit_cycles", 64'(n), 64'd64);
        check("mid_rst_no_resp", 64'(b_pulses - pulses0), 64'd0);
        check("mid_rst_byte300", b_dbg_data, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
